// File: rtl/calculator.sv
// Four-digit hex add/subtract calculator: input debouncers, entry FSM, 16-bit
// adder/subtractor and a multiplexed common-anode 7-segment scanner.
module calculator #(
    parameter int unsigned REFRESH_OVERFLOW = 100000,
    parameter int unsigned DB_OVERFLOW      = 1000000,
    parameter int unsigned SLIDER_OVERFLOW  = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_clr_undeb,
    input  logic       button_ent_undeb,
    input  logic       slider_1_undeb,
    input  logic       slider_2_undeb,
    input  logic       slider_3_undeb,
    input  logic       slider_4_undeb,
    input  logic       slider_arith_undeb,
    output logic [3:0] digit_select,
    output logic [6:0] led_select
);

    localparam int unsigned NumIn  = 7;
    localparam int unsigned MaxOvf = (DB_OVERFLOW > SLIDER_OVERFLOW) ? DB_OVERFLOW
                                                                     : SLIDER_OVERFLOW;
    localparam int unsigned CntW   = (MaxOvf > 0) ? $clog2(MaxOvf + 1) : 1;
    localparam int unsigned RefW   = (REFRESH_OVERFLOW > 1) ? $clog2(REFRESH_OVERFLOW) : 1;

    typedef enum logic [1:0] {StEnterA, StEnterB, StResult} state_e;

    // Bit order: 0 clear, 1 enter, 2..5 slider_1..slider_4, 6 arith.
    logic [NumIn-1:0] raw;
    logic [NumIn-1:0] sync1_q, sync2_q;
    logic [NumIn-1:0] db_q, db_d;
    logic [CntW-1:0]  cnt_q [NumIn];
    logic [CntW-1:0]  cnt_d [NumIn];
    logic [5:0]       db_prev_q;
    logic [5:0]       rise;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [15:0] result, disp_val;

    logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      dig_sel_q, dig_sel_d;
    logic [6:0]      led_q, led_d;
    logic [3:0]      nibble;

    assign raw = {slider_arith_undeb, slider_4_undeb, slider_3_undeb, slider_2_undeb,
                  slider_1_undeb, button_ent_undeb, button_clr_undeb};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Lockout debounce: accept a change only when idle, then ignore input until the
    // counter drains back to zero.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NumIn; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - CntW'(1);
            end else if (sync2_q[i] != db_q[i]) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = (i < 2) ? CntW'(DB_OVERFLOW) : CntW'(SLIDER_OVERFLOW);
            end
        end
    end

    assign rise = db_q[5:0] & ~db_prev_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (rise[0]) begin
            a_d     = '0;
            b_d     = '0;
            state_d = StEnterA;
        end else if (rise[1]) begin
            unique case (state_q)
                StEnterA: begin
                    state_d = StEnterB;
                    b_d     = '0;
                end
                StEnterB: state_d = StResult;
                StResult: begin
                    state_d = StEnterA;
                    a_d     = '0;
                    b_d     = '0;
                end
                default:  state_d = StEnterA;
            endcase
        end else begin
            // slider_1 edits the most significant digit; digits wrap without carry.
            for (int k = 0; k < 4; k++) begin
                if (rise[2+k]) begin
                    if (state_q == StEnterA) begin
                        a_d[4*(3-k) +: 4] = a_q[4*(3-k) +: 4] + 4'd1;
                    end else if (state_q == StEnterB) begin
                        b_d[4*(3-k) +: 4] = b_q[4*(3-k) +: 4] + 4'd1;
                    end
                end
            end
        end
    end

    assign result = db_q[6] ? (a_q - b_q) : (a_q + b_q);

    always_comb begin
        unique case (state_q)
            StEnterA: disp_val = a_q;
            StEnterB: disp_val = b_q;
            default:  disp_val = result;
        endcase
    end

    always_comb begin
        ref_cnt_d = ref_cnt_q + RefW'(1);
        idx_d     = idx_q;
        if (ref_cnt_q == RefW'(REFRESH_OVERFLOW - 1)) begin
            ref_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end
        nibble    = disp_val[{idx_q, 2'b00} +: 4];
        dig_sel_d = ~(4'b0001 << idx_q);
        led_d     = hex_to_seg(nibble);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= '0;
            end
            state_q   <= StEnterA;
            a_q       <= '0;
            b_q       <= '0;
            ref_cnt_q <= '0;
            idx_q     <= '0;
            dig_sel_q <= 4'b1110;
            led_q     <= 7'b1000000;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q[5:0];
            for (int i = 0; i < NumIn; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ref_cnt_q <= ref_cnt_d;
            idx_q     <= idx_d;
            dig_sel_q <= dig_sel_d;
            led_q     <= led_d;
        end
    end

    assign digit_select = dig_sel_q;
    assign led_select   = led_q;

endmodule

// File: tb/tb_calculator.sv
// Self-checking bench for calculator: directed vector table, corner-case sequences
// and random actions scored against an operand/state model via display decoding.
module tb_calculator;

    localparam int unsigned RefOvf = 2;
    localparam int unsigned DbOvf  = 8;
    localparam int unsigned SlOvf  = 2;

    // Action codes: 0..3 slider_1..4, 4 enter, 5 clear, 6 arith=1, 7 arith=0.
    typedef struct {
        int          act;
        logic [15:0] exp;
    } vec_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0, ent = 1'b0, arith = 1'b0;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0;
    logic [3:0] digit_select;
    logic [6:0] led_select;

    int n_pass  = 0;
    int n_total = 0;

    int          m_state = 0;
    logic [15:0] m_a     = '0;
    logic [15:0] m_b     = '0;
    bit          m_arith = 1'b0;

    vec_t vecs [21];

    calculator #(
        .REFRESH_OVERFLOW(RefOvf),
        .DB_OVERFLOW     (DbOvf),
        .SLIDER_OVERFLOW (SlOvf)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .button_clr_undeb  (clr),
        .button_ent_undeb  (ent),
        .slider_1_undeb    (s1),
        .slider_2_undeb    (s2),
        .slider_3_undeb    (s3),
        .slider_4_undeb    (s4),
        .slider_arith_undeb(arith),
        .digit_select      (digit_select),
        .led_select        (led_select)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    function automatic logic [15:0] model_disp();
        if (m_state == 0) return m_a;
        if (m_state == 1) return m_b;
        return m_arith ? 16'(m_a - m_b) : 16'(m_a + m_b);
    endfunction

    task automatic model_apply(input int act);
        int v, sh, nib;
        if (act < 4) begin
            if (m_state < 2) begin
                v   = (m_state == 0) ? int'(m_a) : int'(m_b);
                sh  = 4 * (3 - act);
                nib = (((v >> sh) & 15) + 1) % 16;
                v   = (v & ~(15 << sh)) | (nib << sh);
                if (m_state == 0) m_a = 16'(v);
                else              m_b = 16'(v);
            end
        end else if (act == 4) begin
            if (m_state == 0) begin
                m_state = 1;
                m_b     = '0;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 0;
                m_a     = '0;
                m_b     = '0;
            end
        end else if (act == 5) begin
            m_state = 0;
            m_a     = '0;
            m_b     = '0;
        end else begin
            m_arith = (act == 6);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic val);
        case (which)
            0:       s1  = val;
            1:       s2  = val;
            2:       s3  = val;
            3:       s4  = val;
            4:       ent = val;
            default: clr = val;
        endcase
    endtask

    task automatic do_action(input int act, input int width);
        if (act >= 6) begin
            arith = (act == 6);
            tick(16);
        end else begin
            drive(act, 1'b1);
            tick(width);
            drive(act, 1'b0);
            tick(26);
        end
        model_apply(act);
    endtask

    task automatic check_eq(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // Watch a full scan and rebuild the displayed 16-bit value from the segments.
    task automatic read_display(output logic [15:0] val, output bit ok);
        logic [3:0] seen;
        int d, nib;
        val  = '0;
        ok   = 1'b1;
        seen = '0;
        for (int c = 0; c < 4 * RefOvf + 4; c++) begin
            @(negedge clk);
            case (digit_select)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: begin
                    d  = -1;
                    ok = 1'b0;
                end
            endcase
            nib = -1;
            for (int n = 0; n < 16; n++) begin
                if (seg_of(n) === led_select) nib = n;
            end
            if (nib < 0) ok = 1'b0;
            if (d >= 0 && nib >= 0) begin
                if (seen[d] && val[4*d +: 4] != 4'(nib)) ok = 1'b0;
                val[4*d +: 4] = 4'(nib);
                seen[d]       = 1'b1;
            end
        end
        if (seen != 4'hF) ok = 1'b0;
    endtask

    task automatic check_disp(input string name, input logic [15:0] exp);
        logic [15:0] v;
        bit ok;
        read_display(v, ok);
        n_total++;
        if (ok && v === exp) n_pass++;
        else $display("FAIL %s: display %h (decodable %0d), expected %h", name, v, ok, exp);
    endtask

    initial begin
        logic [3:0] prev, cur;
        int  run, changes;
        bit  order_ok, dwell_ok, first;
        int  act, width;

        vecs[0]  = '{0, 16'h1000};
        vecs[1]  = '{1, 16'h1100};
        vecs[2]  = '{2, 16'h1110};
        vecs[3]  = '{3, 16'h1111};
        vecs[4]  = '{4, 16'h0000};
        vecs[5]  = '{0, 16'h1000};
        vecs[6]  = '{1, 16'h1100};
        vecs[7]  = '{2, 16'h1110};
        vecs[8]  = '{3, 16'h1111};
        vecs[9]  = '{4, 16'h2222};
        vecs[10] = '{6, 16'h0000};
        vecs[11] = '{7, 16'h2222};
        vecs[12] = '{1, 16'h2222};
        vecs[13] = '{4, 16'h0000};
        vecs[14] = '{3, 16'h0001};
        vecs[15] = '{4, 16'h0000};
        vecs[16] = '{2, 16'h0010};
        vecs[17] = '{6, 16'h0010};
        vecs[18] = '{4, 16'hFFF1};
        vecs[19] = '{5, 16'h0000};
        vecs[20] = '{7, 16'h0000};

        // Reset held: outputs at their reset pattern even while inputs wiggle.
        s1 = 1'b1;
        tick(4);
        s1 = 1'b0;
        tick(2);
        @(negedge clk);
        check_eq("reset_digit_select", 16'(digit_select), 16'h000E);
        check_eq("reset_led_select", 16'(led_select), 16'h0040);
        tick(1);
        reset = 1'b1;
        tick(1);
        check_disp("post_reset", 16'h0000);

        // Scan rotates one digit left at a time, each lit for exactly RefOvf cycles.
        order_ok = 1'b1;
        dwell_ok = 1'b1;
        first    = 1'b1;
        changes  = 0;
        @(negedge clk);
        prev = digit_select;
        run  = 1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            cur = digit_select;
            if (cur == prev) begin
                run++;
            end else begin
                changes++;
                if (cur != {prev[2:0], prev[3]}) order_ok = 1'b0;
                if (!first && run != int'(RefOvf)) dwell_ok = 1'b0;
                first = 1'b0;
                run   = 1;
                prev  = cur;
            end
        end
        check_eq("scan_order", 16'(order_ok && changes >= 8), 16'h0001);
        check_eq("scan_dwell", 16'(dwell_ok), 16'h0001);
        tick(1);

        for (int i = 0; i < 21; i++) begin
            do_action(vecs[i].act, (vecs[i].act < 4) ? 10 : 5);
            check_disp($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Digit wrap F->0 without carry, then 1 - 2 wraps to FFFF.
        for (int i = 0; i < 17; i++) do_action(3, 4);
        check_disp("wrap_digit", 16'h0001);
        do_action(4, 5);
        do_action(3, 4);
        do_action(3, 4);
        do_action(6, 0);
        check_disp("wrap_b", 16'h0002);
        do_action(4, 5);
        check_disp("wrap_result", 16'hFFFF);
        @(negedge clk);
        check_eq("wrap_seg", 16'(led_select), 16'h000E);
        tick(1);
        do_action(5, 5);
        check_disp("clr_in_result", 16'h0000);
        do_action(7, 0);

        // Clear during operand B entry.
        do_action(0, 4);
        do_action(4, 5);
        do_action(1, 4);
        check_disp("b_entry", 16'h0100);
        do_action(5, 5);
        check_disp("clr_in_b", 16'h0000);
        do_action(3, 4);
        check_disp("after_clr_edits_a", 16'h0001);

        // Clear and enter together: clear wins, so next enter only reaches ENTER_B.
        clr = 1'b1;
        ent = 1'b1;
        tick(5);
        clr = 1'b0;
        ent = 1'b0;
        tick(26);
        model_apply(5);
        check_disp("clr_ent_same_cycle", 16'h0000);
        do_action(3, 4);
        do_action(4, 5);
        do_action(4, 5);
        check_disp("clr_won_result", model_disp());

        // Bouncing enter from ENTER_A with A=5 must produce exactly one event.
        do_action(5, 5);
        for (int i = 0; i < 5; i++) do_action(3, 3);
        check_disp("bounce_setup", 16'h0005);
        for (int i = 0; i < 6; i++) begin
            ent = (i % 2 == 0);
            tick(1);
        end
        ent = 1'b0;
        tick(26);
        model_apply(4);
        check_disp("bounce_one_enter", 16'h0000);
        do_action(3, 3);
        do_action(4, 5);
        check_disp("bounce_result", 16'h0006);

        // Reset mid-entry restarts in ENTER_A with A cleared.
        do_action(5, 5);
        do_action(0, 4);
        check_disp("pre_reset_a", 16'h1000);
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        m_state = 0;
        m_a     = '0;
        m_b     = '0;
        tick(4);
        check_disp("mid_reset", 16'h0000);
        do_action(3, 4);
        check_disp("post_mid_reset_edit", 16'h0001);

        for (int i = 0; i < 40; i++) begin
            act   = int'($urandom_range(0, 7));
            width = (act < 4) ? int'($urandom_range(3, 6)) : int'($urandom_range(3, 10));
            do_action(act, width);
            check_disp($sformatf("rand%0d_act%0d", i, act), model_disp());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/calculator.md
# calculator

Four-digit hexadecimal add/subtract calculator driven by debounced switches and push-buttons, with output on a multiplexed common-anode 7-segment display. The user enters operand A, presses enter, enters operand B, presses enter again, and the result is shown. It is the top-level block of the calculator board design and contains the input debouncers, the entry state machine, the 16-bit adder/subtractor and the display scanner.

## Interface
- REFRESH_OVERFLOW, default 100000: clock cycles each display digit stays lit before the scanner advances.
- DB_OVERFLOW, default 1000000: lockout length in cycles for the button debouncers.
- SLIDER_OVERFLOW, default 1000000: lockout length in cycles for the slider debouncers.
- clk  input  1  system clock; the block's only clock.
- reset  input  1  asynchronous, active-low reset.
- button_clr_undeb  input  1  raw clear button, active-high.
- button_ent_undeb  input  1  raw enter button, active-high.
- slider_1_undeb … slider_4_undeb  input  1 each  raw digit-increment switches; slider_1 controls digit 3 (most significant), slider_4 controls digit 0.
- slider_arith_undeb  input  1  raw operation select: 0 = add, 1 = subtract.
- digit_select  output  4  active-low one-hot digit enable; bit 0 drives the rightmost digit.
- led_select  output  7  active-low segments, ordered {g,f,e,d,c,b,a}.

## Operation
- **Debounce.** Every raw input passes through a 2-FF synchronizer, then a lockout debouncer.
  - The debouncer holds a stable value and a counter.
  - When the synchronized input differs from the stable value and the counter is 0: the stable value takes the input and the counter loads the OVERFLOW value.
  - The counter then decrements to 0. Input changes during lockout are ignored.
  - Buttons use DB_OVERFLOW; sliders, including the arith slider, use SLIDER_OVERFLOW.
- **Events.** Actions fire on a rising edge of a debounced signal, one clock wide. slider_arith acts on its debounced level, not on edges.
- **Operands.** A and B are 16 bits each: four hex digits, each 4 bits.
- **Digit increment.** A rising edge on slider_n increments the corresponding digit of the operand currently being edited. The digit wraps F→0 with no carry into the neighbouring digit.
- **State machine.**
  - ENTER_A (reset state): sliders edit A; display shows A. Enter → ENTER_B, with B cleared to 0.
  - ENTER_B: sliders edit B; display shows B. Enter → RESULT.
  - RESULT: sliders are ignored. Display shows R, where R = A+B mod 2^16 (arith=0) or A−B mod 2^16 (arith=1, two's-complement wrap). R is combinational, so changing arith updates the display without re-entry. Enter → ENTER_A, with A and B cleared to 0.
- **Clear.** A clear edge in any state sets A = B = 0 and goes to ENTER_A.
- **Simultaneous events.** Clear has priority over enter, and enter has priority over a slider edge in the same cycle. Simultaneous slider edges on different digits all apply.
- **Display.**
  - A 2-bit scan index advances 0→1→2→3→0 every REFRESH_OVERFLOW cycles.
  - digit_select = ~(1 << index).
  - led_select is the active-low hex pattern of the selected nibble of the displayed value. Patterns for 0–F: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.

## Timing
- **Reset (reset=0)**, asynchronous:
  - State = ENTER_A, A = B = 0.
  - All debouncer stable values = 0 and counters = 0; synchronizers = 0.
  - Scan index = 0 and refresh counter = 0.
  - digit_select = 4'b1110, led_select = 7'b1000000.
- Releasing reset mid-entry restarts from the ENTER_A state with A = 0.
- **Input latency.** A raw change reaches the debounced output 3 cycles after the input edge: 2 synchronizer stages plus the debouncer register. The resulting action (state or operand update) takes effect one cycle later.
- **Minimum pulses.** A raw pulse of 3 or more cycles is always accepted. The next opposite transition is recognized no earlier than OVERFLOW cycles after acceptance.
- **Display outputs.** Outputs are registered and update one cycle after an index or value change. Each digit is lit for exactly REFRESH_OVERFLOW cycles.

## Test plan
- **Reset.** Hold reset=0 → digit_select=1110, led_select=1000000. After release, a full scan shows "0000".
- **Operand A entry.** Parameters 2/8/2; pulse each of slider_1..4 once for 10 cycles → A=0x1111. Display shows 1111 and each digit's pattern is 1111001.
- **Result.** Enter (5-cycle pulse), enter B=0x1111 the same way, enter again → RESULT shows 0x2222. Raise arith → shows 0x0000; lower arith → 0x2222.
- **Wrap.** Pulse slider_4 17 times → digit 0 = 1. A=0x0001, B=0x0002, arith=1 → result 0xFFFF, segments 0001110 on every digit.
- **Clear.** Pressing clear during ENTER_B or RESULT → ENTER_A, display "0000". Clear and enter asserted in the same cycle → clear wins.
- **Bounce rejection.** Toggle button_ent_undeb every cycle for 6 cycles with DB_OVERFLOW=8 → exactly one enter event, and the state advances by one.
